// File: rtl/mfp_ahb_lite_master_bridge_pkg.sv
// Shared definitions for the MIPSfpga+ single-transfer AHB-Lite master bridge:
// bus encodings, FSM state type and the request legality check.
package mfp_ahb_lite_master_bridge_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  // A request that can never go on the bus: size 3, or an access that is not
  // naturally aligned to its size.
  function automatic logic req_illegal(input logic [1:0] size, input logic [1:0] addr_lo);
    return (size == 2'd3) ||
           ((size == 2'd1) && addr_lo[0]) ||
           ((size == 2'd2) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/mfp_ahb_lite_master_bridge_if.sv
// Bundles the AHB-Lite master signals and the simple request/response port of
// the bridge. The master modport is the bridge's view; slave is the view of
// whatever sits on the other side (bus matrix plus requester).
//
// Handshake: a request is taken on a rising edge where req_valid & req_ready;
// req_ready is high only while the bridge is idle. rsp_valid is a one-cycle
// pulse and rsp_error / rsp_rdata are meaningful only in that cycle.
interface mfp_ahb_lite_master_bridge_if;
  logic [31:0] HADDR;
  logic [2:0]  HBURST;
  logic        HMASTLOCK;
  logic [3:0]  HPROT;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_error;
  logic [31:0] rsp_rdata;

  modport master (
    output HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWRITE, HWDATA,
    input  HRDATA, HREADY, HRESP,
    input  req_valid, req_write, req_size, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_error, rsp_rdata
  );

  modport slave (
    input  HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWRITE, HWDATA,
    output HRDATA, HREADY, HRESP,
    output req_valid, req_write, req_size, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_error, rsp_rdata
  );
endinterface

// File: rtl/mfp_ahb_lite_lane_steer.sv
// Combinational byte-lane steering: replicates right-justified write data onto
// every lane it may occupy, and pulls read data down from its lane with
// zero extension to the transfer size.
module mfp_ahb_lite_lane_steer
  import mfp_ahb_lite_master_bridge_pkg::*;
(
  input  logic [2:0]  i_wr_size,
  input  logic [31:0] i_wr_data,
  input  logic [2:0]  i_rd_size,
  input  logic [1:0]  i_rd_addr_lo,
  input  logic [31:0] i_rd_data,
  output logic [31:0] o_wr_lanes,
  output logic [31:0] o_rd_data
);

  logic [31:0] w_rd_shift;

  assign w_rd_shift = i_rd_data >> {i_rd_addr_lo, 3'b000};

  // Write replication: a slave may sample any lane, so every lane of the
  // addressed size carries the same data.
  always_comb begin
    o_wr_lanes = i_wr_data;
    case (i_wr_size)
      HSIZE_BYTE: o_wr_lanes = {4{i_wr_data[7:0]}};
      HSIZE_HALF: o_wr_lanes = {2{i_wr_data[15:0]}};
      default:    o_wr_lanes = i_wr_data;
    endcase
  end

  // Read extraction: shift the addressed lane down, then zero-extend.
  always_comb begin
    o_rd_data = w_rd_shift;
    case (i_rd_size)
      HSIZE_BYTE: o_rd_data = {24'h0, w_rd_shift[7:0]};
      HSIZE_HALF: o_rd_data = {16'h0, w_rd_shift[15:0]};
      default:    o_rd_data = w_rd_shift;
    endcase
  end

endmodule

// File: rtl/mfp_ahb_lite_master_bridge.sv
// Single-transfer AHB-Lite initiator: turns one request into one NONSEQ/SINGLE
// transfer, handles wait states, two-cycle ERROR responses, lane steering and
// rejects misaligned/illegal requests without touching the bus.
// Optional stall timeout: define MFP_AHB_MASTER_TIMEOUT_EN to enable it.
module mfp_ahb_lite_master_bridge
  import mfp_ahb_lite_master_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  mfp_ahb_lite_master_bridge_if.master  bus,
  output state_t                        o_dbg_state
);

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_htrans, w_htrans_nxt;
  logic [31:0] r_haddr, w_haddr_nxt;
  logic [2:0]  r_hsize, w_hsize_nxt;
  logic        r_hwrite, w_hwrite_nxt;
  logic [31:0] r_hwdata, w_hwdata_nxt;
  logic        r_rsp_valid, w_rsp_valid_nxt;
  logic        r_rsp_error, w_rsp_error_nxt;
  logic [31:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic [31:0] w_wr_lanes;
  logic [31:0] w_rd_data;
  logic        w_tmo_hit;

  mfp_ahb_lite_lane_steer u_lane_steer (
    .i_wr_size    ({1'b0, bus.req_size}),
    .i_wr_data    (bus.req_wdata),
    .i_rd_size    (r_hsize),
    .i_rd_addr_lo (r_haddr[1:0]),
    .i_rd_data    (bus.HRDATA),
    .o_wr_lanes   (w_wr_lanes),
    .o_rd_data    (w_rd_data)
  );

`ifdef MFP_AHB_MASTER_TIMEOUT_EN
  localparam logic [15:0] TMO_LIM = 16'(TIMEOUT_CYCLES);
  logic [15:0] r_tmo_cnt;

  // Stall counter: held at zero while idle so each accepted transfer starts
  // fresh; counts every bus-phase cycle in which the slave holds HREADY low.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_tmo_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      r_tmo_cnt <= '0;
    end else if (!bus.HREADY) begin
      r_tmo_cnt <= r_tmo_cnt + 16'd1;
    end
  end

  // The hit fires on the stalled cycle that brings the count to the limit.
  assign w_tmo_hit = (r_state != ST_IDLE) && !bus.HREADY && (r_tmo_cnt == TMO_LIM - 16'd1);
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
  assign w_tmo_hit    = 1'b0;
`endif

  // State and registered bus/response outputs.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state     <= ST_IDLE;
      r_htrans    <= HTRANS_IDLE;
      r_haddr     <= '0;
      r_hsize     <= HSIZE_BYTE;
      r_hwrite    <= 1'b0;
      r_hwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_error <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_htrans    <= w_htrans_nxt;
      r_haddr     <= w_haddr_nxt;
      r_hsize     <= w_hsize_nxt;
      r_hwrite    <= w_hwrite_nxt;
      r_hwdata    <= w_hwdata_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_error <= w_rsp_error_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
    end
  end

  // Next-state and next-output decode; address-phase and write data hold by
  // default, the response fields default to an idle (zero) pulse.
  always_comb begin
    w_state_nxt     = r_state;
    w_htrans_nxt    = r_htrans;
    w_haddr_nxt     = r_haddr;
    w_hsize_nxt     = r_hsize;
    w_hwrite_nxt    = r_hwrite;
    w_hwdata_nxt    = r_hwdata;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_error_nxt = 1'b0;
    w_rsp_rdata_nxt = '0;

    case (r_state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (req_illegal(bus.req_size, bus.req_addr[1:0])) begin
            w_rsp_valid_nxt = 1'b1;
            w_rsp_error_nxt = 1'b1;
          end else begin
            w_haddr_nxt  = bus.req_addr;
            w_hsize_nxt  = {1'b0, bus.req_size};
            w_hwrite_nxt = bus.req_write;
            w_hwdata_nxt = w_wr_lanes;
            w_htrans_nxt = HTRANS_NONSEQ;
            w_state_nxt  = ST_ADDR;
          end
        end
      end
      ST_ADDR: begin
        if (bus.HREADY) begin
          w_htrans_nxt = HTRANS_IDLE;
          w_state_nxt  = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bus.HRESP) begin
          // First ERROR cycle should have HREADY low; if a slave collapses it
          // to one cycle, still report the error rather than hang.
          if (bus.HREADY) begin
            w_rsp_valid_nxt = 1'b1;
            w_rsp_error_nxt = 1'b1;
            w_state_nxt     = ST_IDLE;
          end else begin
            w_state_nxt = ST_ERR;
          end
        end else if (bus.HREADY) begin
          w_rsp_valid_nxt = 1'b1;
          w_rsp_rdata_nxt = r_hwrite ? 32'h0 : w_rd_data;
          w_state_nxt     = ST_IDLE;
        end
      end
      ST_ERR: begin
        if (bus.HREADY) begin
          w_rsp_valid_nxt = 1'b1;
          w_rsp_error_nxt = 1'b1;
          w_state_nxt     = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Debug recovery: abandon a transfer the slave never completes.
    if (w_tmo_hit) begin
      w_htrans_nxt    = HTRANS_IDLE;
      w_rsp_valid_nxt = 1'b1;
      w_rsp_error_nxt = 1'b1;
      w_rsp_rdata_nxt = '0;
      w_state_nxt     = ST_IDLE;
    end
  end

  assign bus.HADDR     = r_haddr;
  assign bus.HBURST    = HBURST_SINGLE;
  assign bus.HMASTLOCK = 1'b0;
  assign bus.HPROT     = HPROT_DEFAULT;
  assign bus.HSIZE     = r_hsize;
  assign bus.HTRANS    = r_htrans;
  assign bus.HWRITE    = r_hwrite;
  assign bus.HWDATA    = r_hwdata;
  assign bus.req_ready = (r_state == ST_IDLE);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_error = r_rsp_error;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_mfp_ahb_lite_master_bridge.sv
// Directed bench for mfp_ahb_lite_master_bridge: a vector table of requests
// with hand-computed bus and response expectations, plus hand-written
// sequences for reset behaviour and (with MFP_AHB_MASTER_TIMEOUT_EN) timeout.
module tb_mfp_ahb_lite_master_bridge;
  import mfp_ahb_lite_master_bridge_pkg::*;

  localparam int TB_TMO = 8;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] hrdata;
    int          waits;
    logic        slv_err;
    logic        illegal;
    logic [31:0] exp_hwdata;
    logic [31:0] exp_rdata;
  } vec_t;

  logic   HCLK;
  logic   HRESETn;
  state_t dbg_state;
  int     n_checks;
  int     n_fail;
  int     cur_vec;
  vec_t   vecs[14];

  mfp_ahb_lite_master_bridge_if bus_if ();

  mfp_ahb_lite_master_bridge #(
    .TIMEOUT_CYCLES (TB_TMO)
  ) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .bus         (bus_if),
    .o_dbg_state (dbg_state)
  );

  // Clock
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL v%0d %s: got %h expected %h", cur_vec, name, act, exp);
    end
  endtask

  // Called at a falling edge; the request is taken on the next rising edge.
  // Slave responses are scheduled by cycle index k after acceptance.
  task automatic run_vec(input vec_t v);
    int lat;
    logic exp_err;
    lat     = v.illegal ? 1 : (v.slv_err ? 4 + v.waits : 3 + v.waits);
    exp_err = v.illegal | v.slv_err;
    chk("req_ready_c0", 32'(bus_if.req_ready), 32'd1);
    bus_if.req_valid = 1'b1;
    bus_if.req_write = v.wr;
    bus_if.req_size  = v.size;
    bus_if.req_addr  = v.addr;
    bus_if.req_wdata = v.wdata;
    bus_if.HRDATA    = v.hrdata;
    bus_if.HRESP     = 1'b0;
    bus_if.HREADY    = 1'($urandom_range(0, 1));
    for (int k = 1; k <= lat; k++) begin
      @(negedge HCLK);
      bus_if.req_valid = 1'b0;
      if (k == lat) begin
        chk("rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
        chk("rsp_error", 32'(bus_if.rsp_error), 32'(exp_err));
        if (!exp_err) chk("rsp_rdata", bus_if.rsp_rdata, v.exp_rdata);
      end else begin
        chk("rsp_valid_early", 32'(bus_if.rsp_valid), 32'd0);
      end
      if (!v.illegal && k == 1) begin
        chk("htrans_nonseq", 32'(bus_if.HTRANS), 32'(HTRANS_NONSEQ));
        chk("haddr", bus_if.HADDR, v.addr);
        chk("hsize", 32'(bus_if.HSIZE), {30'd0, v.size});
        chk("hwrite", 32'(bus_if.HWRITE), 32'(v.wr));
      end else begin
        chk("htrans_idle", 32'(bus_if.HTRANS), 32'(HTRANS_IDLE));
      end
      if (!v.illegal && v.wr && k < lat) chk("hwdata", bus_if.HWDATA, v.exp_hwdata);
      if (k < lat) begin
        if (k == 1) begin
          bus_if.HREADY = 1'b1; bus_if.HRESP = 1'b0;
        end else if (k < 2 + v.waits) begin
          bus_if.HREADY = 1'b0; bus_if.HRESP = 1'b0;
        end else if (k == 2 + v.waits) begin
          bus_if.HREADY = !v.slv_err; bus_if.HRESP = v.slv_err;
        end else begin
          bus_if.HREADY = 1'b1; bus_if.HRESP = v.slv_err;
        end
      end
    end
    bus_if.HRESP = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cur_vec  = -1;
    //            wr    size  addr           wdata          hrdata         wt sle  ill   exp_hwdata     exp_rdata
    vecs[0]  = '{1'b1, 2'd2, 32'h1F80_0004, 32'hDEAD_BEEF, 32'h0000_0000, 0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[1]  = '{1'b0, 2'd0, 32'h1F80_0003, 32'h0000_0000, 32'hA500_0000, 2, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_00A5};
    vecs[2]  = '{1'b1, 2'd1, 32'h1F80_0001, 32'h0000_1234, 32'h0000_0000, 0, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000};
    vecs[3]  = '{1'b0, 2'd1, 32'h1F80_0002, 32'h0000_0000, 32'hBEEF_1234, 1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_BEEF};
    vecs[4]  = '{1'b1, 2'd0, 32'h1F80_0011, 32'hFFFF_FF5A, 32'h0000_0000, 0, 1'b0, 1'b0, 32'h5A5A_5A5A, 32'h0000_0000};
    vecs[5]  = '{1'b1, 2'd1, 32'h1F80_0012, 32'h1111_CAFE, 32'h0000_0000, 3, 1'b0, 1'b0, 32'hCAFE_CAFE, 32'h0000_0000};
    vecs[6]  = '{1'b0, 2'd2, 32'h0000_0008, 32'h0000_0000, 32'h89AB_CDEF, 0, 1'b0, 1'b0, 32'h0000_0000, 32'h89AB_CDEF};
    vecs[7]  = '{1'b0, 2'd3, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000};
    vecs[8]  = '{1'b1, 2'd2, 32'h1F80_0006, 32'h0BAD_F00D, 32'h0000_0000, 0, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000};
    vecs[9]  = '{1'b0, 2'd2, 32'h1F80_0000, 32'h0000_0000, 32'h1234_5678, 0, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000};
    vecs[10] = '{1'b0, 2'd0, 32'h1F80_0021, 32'h0000_0000, 32'h1234_5678, 0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0056};
    vecs[11] = '{1'b0, 2'd1, 32'h1F80_0020, 32'h0000_0000, 32'h1234_5678, 0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_5678};
    vecs[12] = '{1'b1, 2'd0, 32'h1F80_0022, 32'h0000_00C3, 32'h0000_0000, 1, 1'b1, 1'b0, 32'hC3C3_C3C3, 32'h0000_0000};
    vecs[13] = '{1'b0, 2'd0, 32'h0000_0000, 32'h0000_0000, 32'h8765_4321, 0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0021};

    // Reset
    HRESETn          = 1'b0;
    bus_if.req_valid = 1'b0;
    bus_if.req_write = 1'b0;
    bus_if.req_size  = 2'd0;
    bus_if.req_addr  = 32'h0;
    bus_if.req_wdata = 32'h0;
    bus_if.HRDATA    = 32'h0;
    bus_if.HREADY    = 1'b1;
    bus_if.HRESP     = 1'b0;
    @(negedge HCLK);
    chk("rst_htrans", 32'(bus_if.HTRANS), 32'(HTRANS_IDLE));
    chk("rst_haddr", bus_if.HADDR, 32'h0);
    chk("rst_hwdata", bus_if.HWDATA, 32'h0);
    chk("rst_hwrite", 32'(bus_if.HWRITE), 32'd0);
    chk("rst_hsize", 32'(bus_if.HSIZE), 32'd0);
    chk("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    chk("rst_rsp_error", 32'(bus_if.rsp_error), 32'd0);
    chk("rst_rsp_rdata", bus_if.rsp_rdata, 32'h0);
    chk("rst_req_ready", 32'(bus_if.req_ready), 32'd1);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("hburst", 32'(bus_if.HBURST), 32'd0);
    chk("hprot", 32'(bus_if.HPROT), 32'h3);
    chk("hmastlock", 32'(bus_if.HMASTLOCK), 32'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Vector table, issued back to back.
    for (int i = 0; i < 14; i++) begin
      cur_vec = i;
      run_vec(vecs[i]);
    end

    // Reset while the address phase is stalled.
    cur_vec = 100;
    bus_if.req_valid = 1'b1;
    bus_if.req_write = 1'b0;
    bus_if.req_size  = 2'd2;
    bus_if.req_addr  = 32'h1F80_0040;
    bus_if.HREADY    = 1'b0;
    @(negedge HCLK);
    bus_if.req_valid = 1'b0;
    chk("mid_htrans_nonseq", 32'(bus_if.HTRANS), 32'(HTRANS_NONSEQ));
    #2 HRESETn = 1'b0;
    #1;
    chk("mid_htrans_async", 32'(bus_if.HTRANS), 32'(HTRANS_IDLE));
    chk("mid_haddr_async", bus_if.HADDR, 32'h0);
    chk("mid_req_ready", 32'(bus_if.req_ready), 32'd1);
    @(negedge HCLK);
    HRESETn       = 1'b1;
    bus_if.HREADY = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge HCLK);
      chk("mid_no_rsp", 32'(bus_if.rsp_valid), 32'd0);
      chk("mid_ready", 32'(bus_if.req_ready), 32'd1);
    end
    cur_vec = 101;
    run_vec(vecs[0]);

`ifdef MFP_AHB_MASTER_TIMEOUT_EN
    // Slave never raises HREADY: expect an error response after TB_TMO stalls.
    cur_vec = 200;
    bus_if.req_valid = 1'b1;
    bus_if.req_write = 1'b0;
    bus_if.req_size  = 2'd2;
    bus_if.req_addr  = 32'h1F80_0080;
    bus_if.HREADY    = 1'b0;
    for (int k = 1; k <= TB_TMO + 1; k++) begin
      @(negedge HCLK);
      bus_if.req_valid = 1'b0;
      if (k == TB_TMO + 1) begin
        chk("tmo_rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
        chk("tmo_rsp_error", 32'(bus_if.rsp_error), 32'd1);
        chk("tmo_htrans", 32'(bus_if.HTRANS), 32'(HTRANS_IDLE));
        chk("tmo_req_ready", 32'(bus_if.req_ready), 32'd1);
      end else begin
        chk("tmo_no_rsp", 32'(bus_if.rsp_valid), 32'd0);
      end
    end
    bus_if.HREADY = 1'b1;
    cur_vec = 201;
    run_vec(vecs[6]);
`endif

    @(negedge HCLK);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
